// File: rtl/keypad_digit_capture_if.sv
// Keypad capture bus: scanner-side key-held flag and position in, captured digits and status out.
interface keypad_digit_capture_if;
  logic       press;
  logic [1:0] pressed_row;
  logic [1:0] pressed_col;
  logic [3:0] new_digit;
  logic [3:0] prev_digit;
  logic       key_valid;
  logic       key_held;

  modport master (
    output press, pressed_row, pressed_col,
    input  new_digit, prev_digit, key_valid, key_held
  );

  modport slave (
    input  press, pressed_row, pressed_col,
    output new_digit, prev_digit, key_valid, key_held
  );
endinterface

// File: rtl/keypad_digit_capture.sv
// Debounces keypad press/release and shifts each accepted key into a two-digit history.
module keypad_digit_capture #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_digit_capture_if.slave kp
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_next;
  logic [3:0]    w_key;
  logic          w_accept;
  logic [3:0]    r_new_digit;
  logic [3:0]    r_prev_digit;
  logic          r_key_valid;
  logic          r_key_held;

  function automatic logic [3:0] decode(input logic [3:0] rc);
    case (rc)
      4'h0: decode = 4'h1;
      4'h1: decode = 4'h2;
      4'h2: decode = 4'h3;
      4'h3: decode = 4'hA;
      4'h4: decode = 4'h4;
      4'h5: decode = 4'h5;
      4'h6: decode = 4'h6;
      4'h7: decode = 4'hB;
      4'h8: decode = 4'h7;
      4'h9: decode = 4'h8;
      4'hA: decode = 4'h9;
      4'hB: decode = 4'hC;
      4'hC: decode = 4'hE;
      4'hD: decode = 4'h0;
      4'hE: decode = 4'hF;
      default: decode = 4'hD;
    endcase
  endfunction

  assign w_key = {kp.pressed_row, kp.pressed_col};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cand_next  = r_cand;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (kp.press) begin
          w_state_next = DB_PRESS;
          w_cand_next  = w_key;
          w_cnt_next   = '0;
        end
      end
      DB_PRESS: begin
        if (!kp.press) begin
          w_state_next = IDLE;
        end else if (w_key != r_cand) begin
          // A different key restarts the debounce window on the new candidate.
          w_cand_next = w_key;
          w_cnt_next  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = HELD;
          w_accept     = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!kp.press) begin
          w_state_next = DB_RELEASE;
          w_cnt_next   = '0;
        end
      end
      DB_RELEASE: begin
        if (kp.press) begin
          w_state_next = HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_cand       <= '0;
      r_new_digit  <= '0;
      r_prev_digit <= '0;
      r_key_valid  <= 1'b0;
      r_key_held   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_cand      <= w_cand_next;
      r_key_valid <= w_accept;
      r_key_held  <= (w_state_next == HELD) || (w_state_next == DB_RELEASE);
      if (w_accept) begin
        r_prev_digit <= r_new_digit;
        r_new_digit  <= decode(r_cand);
      end
    end
  end

  assign kp.new_digit  = r_new_digit;
  assign kp.prev_digit = r_prev_digit;
  assign kp.key_valid  = r_key_valid;
  assign kp.key_held   = r_key_held;

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Directed bench for keypad_digit_capture with a 4-cycle debounce window.
module tb_keypad_digit_capture;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;

  keypad_digit_capture_if kp_if();

  keypad_digit_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one edge and sample outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    if (kp_if.key_valid) pulses++;
  endtask

  task automatic hold(input logic p, input logic [1:0] r, input logic [1:0] c, input int n);
    kp_if.press       = p;
    kp_if.pressed_row = r;
    kp_if.pressed_col = c;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    reset  = 1'b0;
    kp_if.press       = 1'b0;
    kp_if.pressed_row = 2'd0;
    kp_if.pressed_col = 2'd0;
    #12;
    check("rst_new",   kp_if.new_digit,  0);
    check("rst_prev",  kp_if.prev_digit, 0);
    check("rst_valid", kp_if.key_valid,  0);
    check("rst_held",  kp_if.key_held,   0);
    reset = 1'b1;
    hold(0, 0, 0, 2);

    // Clean press row1/col2 -> 6
    pulses = 0;
    hold(1, 1, 2, 4);
    check("t1_valid_E3", kp_if.key_valid, 0);
    check("t1_held_E3",  kp_if.key_held,  0);
    hold(1, 1, 2, 1);
    check("t1_valid_E4", kp_if.key_valid,  1);
    check("t1_new",      kp_if.new_digit,  4'h6);
    check("t1_prev",     kp_if.prev_digit, 4'h0);
    check("t1_held",     kp_if.key_held,   1);
    hold(1, 1, 2, 1);
    check("t1_valid_E5", kp_if.key_valid, 0);
    hold(0, 0, 0, 4);
    check("t1_held_R3", kp_if.key_held, 1);
    hold(0, 0, 0, 1);
    check("t1_held_R4", kp_if.key_held, 0);
    hold(0, 0, 0, 1);
    check("t1_pulses", pulses, 1);

    // Two keys: row0/col0 (1) then row3/col1 (0)
    pulses = 0;
    hold(1, 0, 0, 6);
    hold(0, 0, 0, 6);
    hold(1, 3, 1, 6);
    hold(0, 0, 0, 6);
    check("t2_new",    kp_if.new_digit,  4'h0);
    check("t2_prev",   kp_if.prev_digit, 4'h1);
    check("t2_pulses", pulses, 2);

    // Press bounce never reaches acceptance
    pulses = 0;
    hold(1, 2, 2, 3);
    hold(0, 0, 0, 1);
    hold(1, 2, 2, 3);
    hold(0, 0, 0, 2);
    check("t3_pulses", pulses, 0);
    check("t3_new",    kp_if.new_digit,  4'h0);
    check("t3_prev",   kp_if.prev_digit, 4'h1);
    check("t3_held",   kp_if.key_held,   0);

    // Key change during debounce restarts the window
    pulses = 0;
    hold(1, 0, 3, 2);
    hold(1, 3, 3, 4);
    check("t4_early", pulses, 0);
    hold(1, 3, 3, 1);
    check("t4_valid", kp_if.key_valid,  1);
    check("t4_new",   kp_if.new_digit,  4'hD);
    check("t4_prev",  kp_if.prev_digit, 4'h0);
    hold(0, 0, 0, 6);
    check("t4_pulses", pulses, 1);

    // Release bounce on key 5
    pulses = 0;
    hold(1, 1, 1, 6);
    hold(0, 0, 0, 2);
    hold(1, 1, 1, 1);
    hold(0, 0, 0, 3);
    check("t5_held_mid", kp_if.key_held, 1);
    hold(0, 0, 0, 1);
    check("t5_held_R3", kp_if.key_held, 1);
    hold(0, 0, 0, 1);
    check("t5_held_end", kp_if.key_held,  0);
    check("t5_pulses",   pulses, 1);
    check("t5_new",      kp_if.new_digit,  4'h5);
    check("t5_prev",     kp_if.prev_digit, 4'hD);

    // Same key again shifts normally
    hold(1, 1, 1, 6);
    hold(0, 0, 0, 6);
    check("t6_new",  kp_if.new_digit,  4'h5);
    check("t6_prev", kp_if.prev_digit, 4'h5);

    // Asynchronous reset during HELD, then fresh capture of row2/col0 (7)
    hold(1, 2, 0, 6);
    check("t7_new_pre", kp_if.new_digit, 4'h7);
    #3;
    reset = 1'b0;
    #1;
    check("t7_rst_new",   kp_if.new_digit,  0);
    check("t7_rst_prev",  kp_if.prev_digit, 0);
    check("t7_rst_valid", kp_if.key_valid,  0);
    check("t7_rst_held",  kp_if.key_held,   0);
    #2;
    reset = 1'b1;
    pulses = 0;
    hold(1, 2, 0, 4);
    check("t7_early", pulses, 0);
    hold(1, 2, 0, 1);
    check("t7_valid", kp_if.key_valid,  1);
    check("t7_new",   kp_if.new_digit,  4'h7);
    check("t7_prev",  kp_if.prev_digit, 4'h0);
    hold(0, 0, 0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
